// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: a - b - bin over WIDTH clocks, borrow held in a flop.
// Define SERIAL_SUB_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dif,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic [CW-1:0]    count;
    logic [WIDTH-2:0] res;

    logic             x;
    logic             y;
    logic             d;
    logic             bn;
    logic [WIDTH-1:0] nxt;

`ifdef SERIAL_SUB_OVF_EN
    logic             am;
    logic             bm;
`endif

    // Full-subtractor cell on the current LSBs; nxt is the result word with this bit shifted in.
    always_comb begin
        x   = sa[0];
        y   = sb[0];
        d   = x ^ y ^ br;
        bn  = (~x & y) | (~(x ^ y) & br);
        nxt = {d, res};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            br    <= 1'b0;
            count <= '0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dif   <= '0;
            bo    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            am    <= 1'b0;
            bm    <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        am    <= a[WIDTH-1];
                        bm    <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    br    <= bn;
                    res   <= nxt[WIDTH-1:1];
                    count <= count + 1'b1;
                    // Last bit: publish the whole word at once so dif never shows partial results.
                    if (count == LAST) begin
                        dif   <= nxt;
                        bo    <= bn;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (am != bm) && (d != am);
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8); ovf checks apply when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] dif;
    logic         bo;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .dif   (dif),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .bo    (bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one cycle; return at the negedge where done is seen (or after the bound).
    // lat counts active edges from the start-sampling edge to the edge that raised done.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         output int lat, output int busy_n);
        int k;
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1; busy_n = 0; lat = -1;
        while (k < 40) begin
            if (busy) busy_n++;
            if (done) begin
                lat = k - 1;
                break;
            end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_result(input string name, input int lat,
                                input logic [W-1:0] exp_dif, input logic exp_bo, input logic exp_ovf);
        checks++;
        if (lat !== W) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, W); end
        checks++;
        if (dif !== exp_dif) begin errors++; $display("FAIL %s dif: got %h expected %h", name, dif, exp_dif); end
        checks++;
        if (bo !== exp_bo) begin errors++; $display("FAIL %s bo: got %b expected %b", name, bo, exp_bo); end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== exp_ovf) begin errors++; $display("FAIL %s ovf: got %b expected %b", name, ovf, exp_ovf); end
`else
        if (exp_ovf === 1'bx) $display("note: unexpected x in expected ovf for %s", name);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
        checks++;
        if (dif !== 8'h00) begin errors++; $display("FAIL reset dif: got %h expected 00", dif); end
        checks++;
        if (bo !== 1'b0) begin errors++; $display("FAIL reset bo: got %b expected 0", bo); end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b expected 0", ovf); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, busy_n;
        do_op(8'h05, 8'h03, 1'b0, lat, busy_n);
        check_result("basic", lat, 8'h02, 1'b0, 1'b0);
        checks++;
        if (busy_n !== W + 1) begin errors++; $display("FAIL basic busy_cycles: got %0d expected %0d", busy_n, W + 1); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic done_pulse: got %b expected 0", done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic busy_after: got %b expected 0", busy); end
        checks++;
        if (dif !== 8'h02) begin errors++; $display("FAIL basic dif_hold: got %h expected 02", dif); end
    endtask

    task automatic test_underflow();
        int lat, busy_n;
        do_op(8'h03, 8'h05, 1'b0, lat, busy_n);
        check_result("underflow", lat, 8'hFE, 1'b1, 1'b0);
    endtask

    task automatic test_borrow_in();
        int lat, busy_n;
        do_op(8'h00, 8'h00, 1'b1, lat, busy_n);
        check_result("borrow_in", lat, 8'hFF, 1'b1, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0, lat, busy_n);
        check_result("equal_ff", lat, 8'h00, 1'b0, 1'b0);
        do_op(8'h10, 8'h0F, 1'b1, lat, busy_n);
        check_result("borrow_in_exact", lat, 8'h00, 1'b0, 1'b0);
        do_op(8'h00, 8'h01, 1'b0, lat, busy_n);
        check_result("zero_minus_one", lat, 8'hFF, 1'b1, 1'b0);
        do_op(8'hC3, 8'h5A, 1'b0, lat, busy_n);
        check_result("mixed_bits", lat, 8'h69, 1'b0, 1'b1);
    endtask

    task automatic test_signed_ovf();
        int lat, busy_n;
        do_op(8'h80, 8'h01, 1'b0, lat, busy_n);
        check_result("ovf_neg", lat, 8'h7F, 1'b0, 1'b1);
        do_op(8'h7F, 8'hFF, 1'b0, lat, busy_n);
        check_result("ovf_pos", lat, 8'h80, 1'b1, 1'b1);
    endtask

    // start held high through SHIFT/DONE: first operands must be untouched and the
    // second operation is taken only in the following IDLE cycle.
    task automatic test_busy_protect();
        int k, first_k, second_k, extra_done;
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'hAA; b = 8'h55;
        k = 1; first_k = -1; second_k = -1; extra_done = 0;
        while (k < 60 && second_k < 0) begin
            if (k == 4) begin
                checks++;
                if (dif !== 8'h80) begin errors++; $display("FAIL busy_protect dif_hold_mid: got %h expected 80", dif); end
            end
            if (done) begin
                if (first_k < 0) begin
                    first_k = k;
                    checks++;
                    if (dif !== 8'h0F) begin errors++; $display("FAIL busy_protect first_dif: got %h expected 0F", dif); end
                end else if (k == first_k + 1) begin
                    extra_done++;
                end else begin
                    second_k = k;
                    start = 1'b0;
                    checks++;
                    if (dif !== 8'h55) begin errors++; $display("FAIL busy_protect second_dif: got %h expected 55", dif); end
                    checks++;
                    if (bo !== 1'b0) begin errors++; $display("FAIL busy_protect second_bo: got %b expected 0", bo); end
                end
            end
            if (second_k < 0) begin
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        checks++;
        if (first_k !== W + 1) begin errors++; $display("FAIL busy_protect first_done_at: got %0d expected %0d", first_k, W + 1); end
        checks++;
        if (second_k !== 2 * W + 3) begin errors++; $display("FAIL busy_protect second_done_at: got %0d expected %0d", second_k, 2 * W + 3); end
        checks++;
        if (extra_done !== 0) begin errors++; $display("FAIL busy_protect done_width: got %0d expected 0", extra_done); end
        @(negedge clk);
    endtask

    task automatic test_midop_reset();
        int k, seen_done, lat, busy_n;
        @(negedge clk);
        a = 8'h22; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_done = 0;
        for (k = 1; k < 4; k++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midop_reset busy: got %b expected 0", busy); end
        checks++;
        if (dif !== 8'h00) begin errors++; $display("FAIL midop_reset dif: got %h expected 00", dif); end
        checks++;
        if (bo !== 1'b0) begin errors++; $display("FAIL midop_reset bo: got %b expected 0", bo); end
        for (k = 0; k < W + 2; k++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        checks++;
        if (seen_done !== 0) begin errors++; $display("FAIL midop_reset done_seen: got %0d expected 0", seen_done); end
        do_op(8'h09, 8'h04, 1'b0, lat, busy_n);
        check_result("after_reset", lat, 8'h05, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_borrow_in();
        test_signed_ovf();
        test_busy_protect();
        test_midop_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
